user_io_scheduler: RTL
======================

// Module: user_io_scheduler
// PURPOSE
//   Time-shares the single 8-bit pad interface (io_in/io_out) between NUM_SLOTS user design slots.
//   Sequences which slot owns the pads, gates each slot's clock enable and inserts guard cycles on every hand-over.
//   Modes: fixed (one slot) or round-robin over an enable mask. Sits between the pad ring and the user slot array.
// PARAMETERS
//   NUM_SLOTS  4  number of user slots (>=2)
//   DWELL_W    8  width of the dwell (cycles-per-slot) field
//   GUARD      2  idle cycles inserted on every slot change (>=1)
// PORTS
//   clk          in   1              single clock
//   reset        in   1              asynchronous, active-high
//   io_in        in   8              pad inputs
//   io_out       out  8              pad outputs
//   slot_in      out  8*NUM_SLOTS    per-slot inputs; slot k = [8k+7:8k]
//   slot_out     in   8*NUM_SLOTS    per-slot outputs
//   slot_clk_en  out  NUM_SLOTS      one-hot clock enable of the active slot
//   cfg_valid    in   1              config request
//   cfg_ready    out  1              config accept-ready
//   cfg_mode     in   1              0 = fixed, 1 = round-robin
//   cfg_slot     in   $clog2(NUM_SLOTS)  fixed slot / round-robin start slot
//   cfg_mask     in   NUM_SLOTS      round-robin enable mask (ignored in fixed mode)
//   cfg_dwell    in   DWELL_W        round-robin: slot runs cfg_dwell+1 cycles
//   active_slot  out  $clog2(NUM_SLOTS)  slot owning the pads
//   busy         out  1              state != IDLE
// BEHAVIOUR
//   - Reset (async): state IDLE; io_out, slot_in, slot_clk_en, active_slot, mask, dwell all 0; cfg_ready 1.
//     Reset mid-RUN zeroes every output immediately, with no guard sequence.
//   - FSM: IDLE -> SWITCH (GUARD cycles) -> RUN; RUN -> SWITCH on slot change; any accepted config with
//     an effective mask of 0 -> IDLE.
//   - Handshake: accept when cfg_valid && cfg_ready. cfg_ready = 1 in IDLE/RUN, 0 in SWITCH.
//     A request held through SWITCH is accepted on the first RUN cycle.
//   - On accept: latch mode, mask and dwell. Effective mask = onehot(cfg_slot) in fixed mode, else cfg_mask.
//     Target = first set mask bit at or after cfg_slot, with wrap. Always enter SWITCH, even if target == active_slot.
//   - SWITCH: slot_clk_en = 0, slot_in = 0, io_out = 0. active_slot updates to target on SWITCH entry.
//   - RUN: slot_clk_en[active] = 1; slot_in[active] <= io_in and other slots = 0 (registered, 1-cycle latency);
//     io_out <= slot_out[active] (registered, 1-cycle latency).
//   - Dwell counter clears on RUN entry. In round-robin mode, when count == dwell: next = next set mask bit after
//     active (wraps at NUM_SLOTS-1 -> 0).
//     next == active (single-bit mask): stay in RUN, clear counter, no guard. Else go to SWITCH.
//     Fixed mode never expires.
//   - Simultaneous config accept and dwell expiry: the config wins; the expiry is discarded.
//   - IDLE: all outputs 0 except cfg_ready = 1.
// CONFIGURATION
//   USER_IO_SCHED_HOLD_EN defined: io_out holds its last RUN value through SWITCH and IDLE (reset still clears it).
//   Not defined: io_out = 0 outside RUN, as above.
// STRUCTURE
//   Package user_io_sched_pkg: state enum {ST_IDLE, ST_SWITCH, ST_RUN}; MODE_FIXED = 1'b0, MODE_RR = 1'b1.
//   Sub-module user_io_next_slot: combinational next-set-bit-after-index finder with wrap.
//     Used for the start slot (inclusive search) and for rotation (exclusive search).
// TESTING
//   1. Reset during RUN with slot 1 active -> next sample: io_out = 0, slot_clk_en = 0, busy = 0, cfg_ready = 1.
//   2. Fixed, cfg_slot = 2 -> 2 cycles with slot_clk_en = 0, then 4'b0100. io_in = 8'hA5 -> slot_in[23:16] = A5
//      one cycle later. slot_out[23:16] = 8'h3C -> io_out = 3C one cycle later.
//   3. RR, mask 4'b1011, dwell 3, start 0 -> slot 0 for 4 cycles, 2 guard, slot 1 for 4, 2 guard, slot 3, 2 guard, slot 0.
//   4. RR, mask 4'b0100, dwell 0 -> slot 2 continuously, slot_clk_en never drops, no SWITCH after entry.
//   5. cfg_valid held during SWITCH -> cfg_ready = 0 until RUN, then accepted. RR with mask 0 -> IDLE, busy = 0, io_out = 0.
//   6. With USER_IO_SCHED_HOLD_EN: io_out = 3C during guard cycles after slot 2; without it io_out = 0.

Source files
------------

// File: rtl/user_io_sched_pkg.sv
// Shared types for the user I/O scheduler: FSM state encoding and mode codes.
package user_io_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWITCH,
    ST_RUN
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/user_io_next_slot.sv
// Finds the first set mask bit at (inclusive) or after (exclusive) idx, wrapping at NUM_SLOTS-1 -> 0.
module user_io_next_slot #(
  parameter int NUM_SLOTS = 4,
  parameter int SW        = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] mask,
  input  logic [SW-1:0]        idx,
  input  logic                 inclusive,
  output logic [SW-1:0]        slot,
  output logic                 found
);

  int pos_i;

  // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    slot  = idx;
    found = 1'b0;
    pos_i = 0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      pos_i = (int'(idx) + (inclusive ? i : i + 1)) % NUM_SLOTS;
      if (mask[pos_i]) begin
        slot  = SW'(pos_i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/user_io_scheduler.sv
// Time-shares the 8-bit pad interface between user slots with guard cycles on every hand-over.
// Optional USER_IO_SCHED_HOLD_EN: io_out keeps its last RUN value through SWITCH and IDLE.
module user_io_scheduler
  import user_io_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int DWELL_W   = 8,
  parameter int GUARD     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   io_in,
  output logic [7:0]                   io_out,
  output logic [8*NUM_SLOTS-1:0]       slot_in,
  input  logic [8*NUM_SLOTS-1:0]       slot_out,
  output logic [NUM_SLOTS-1:0]         slot_clk_en,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic                         cfg_mode,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
  input  logic [NUM_SLOTS-1:0]         cfg_mask,
  input  logic [DWELL_W-1:0]           cfg_dwell,
  output logic [$clog2(NUM_SLOTS)-1:0] active_slot,
  output logic                         busy
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [SW-1:0]        active_q, active_d;
  logic [GW-1:0]        guard_q, guard_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [8*NUM_SLOTS-1:0] slot_in_q, slot_in_d;
  logic [7:0]           io_out_q;

  logic                 accept, run;
  logic [NUM_SLOTS-1:0] eff_mask;
  logic [SW-1:0]        tgt_slot, rot_slot;
  logic                 tgt_found, rot_found;

  // Config handshake: a transfer happens on any clock where cfg_valid && cfg_ready;
  // cfg_ready is low only during SWITCH, so a held request lands on the first RUN cycle.
  assign cfg_ready = (state_q != ST_SWITCH);
  assign accept    = cfg_valid && cfg_ready;
  assign run       = (state_q == ST_RUN);
  assign eff_mask  = (cfg_mode == MODE_RR) ? cfg_mask : (NUM_SLOTS'(1) << cfg_slot);

  user_io_next_slot #(.NUM_SLOTS(NUM_SLOTS), .SW(SW)) u_start (
    .mask      (eff_mask),
    .idx       (cfg_slot),
    .inclusive (1'b1),
    .slot      (tgt_slot),
    .found     (tgt_found)
  );

  user_io_next_slot #(.NUM_SLOTS(NUM_SLOTS), .SW(SW)) u_rotate (
    .mask      (mask_q),
    .idx       (active_q),
    .inclusive (1'b0),
    .slot      (rot_slot),
    .found     (rot_found)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_FIXED;
      mask_q   <= '0;
      dwell_q  <= '0;
      active_q <= '0;
      guard_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      mask_q   <= mask_d;
      dwell_q  <= dwell_d;
      active_q <= active_d;
      guard_q  <= guard_d;
      cnt_q    <= cnt_d;
    end
  end

  // A config accepted on the same cycle as a dwell expiry takes priority over the rotation.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    mask_d   = mask_q;
    dwell_d  = dwell_q;
    active_d = active_q;
    guard_d  = guard_q;
    cnt_d    = cnt_q;
    if (accept) begin
      mode_d  = cfg_mode;
      mask_d  = eff_mask;
      dwell_d = cfg_dwell;
      if (!tgt_found) begin
        state_d  = ST_IDLE;
        active_d = '0;
      end else begin
        state_d  = ST_SWITCH;
        active_d = tgt_slot;
        guard_d  = '0;
      end
    end else begin
      case (state_q)
        ST_SWITCH: begin
          if (guard_q == GW'(GUARD - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            guard_d = guard_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (mode_q == MODE_RR && cnt_q == dwell_q && rot_found) begin
            cnt_d = '0;
            if (rot_slot != active_q) begin
              state_d  = ST_SWITCH;
              active_d = rot_slot;
              guard_d  = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    slot_in_d = '0;
    slot_in_d[int'(active_q)*8 +: 8] = io_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_in_q <= '0;
      io_out_q  <= '0;
    end else begin
      slot_in_q <= run ? slot_in_d : '0;
      if (run) begin
        io_out_q <= slot_out[int'(active_q)*8 +: 8];
      end else begin
`ifdef USER_IO_SCHED_HOLD_EN
        io_out_q <= io_out_q;
`else
        io_out_q <= '0;
`endif
      end
    end
  end

  assign slot_clk_en = run ? (NUM_SLOTS'(1) << active_q) : '0;
  assign slot_in     = run ? slot_in_q : '0;
  assign active_slot = active_q;
  assign busy        = (state_q != ST_IDLE);

`ifdef USER_IO_SCHED_HOLD_EN
  assign io_out = io_out_q;
`else
  assign io_out = run ? io_out_q : 8'h00;
`endif

endmodule
